cm0_dap_slv_ahb_bridge: RTL and testbench

Single-transfer bridge directly downstream of the DAP access port's SLV* bus-master interface. It accepts one SLV request at a time and issues it as a single AHB-Lite transfer, then returns the read data and response to the access port. The SLV port pins connect one-to-one to the AP's SLVADDR/SLVWDATA/SLVTRANS/SLVWRITE/SLVSIZE outputs and SLVRDATA/SLVREADY/SLVRESP inputs.

---
 rtl/cm0_dap_slv_ahb_bridge_if.sv | 44 ++++
 rtl/cm0_dap_slv_ahb_bridge.sv | 181 ++++++++++++++++++
 tb/tb_cm0_dap_slv_ahb_bridge.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cm0_dap_slv_ahb_bridge_if.sv
// SLV* request port and AHB-Lite master port bundles used by cm0_dap_slv_ahb_bridge.
// "master" is the side that initiates the transfer; "slave" is the side that completes it.
interface cm0_dap_slv_if;
    logic [31:0] SLVADDR;
    logic [31:0] SLVWDATA;
    logic [1:0]  SLVTRANS;
    logic        SLVWRITE;
    logic [1:0]  SLVSIZE;
    logic [31:0] SLVRDATA;
    logic        SLVREADY;
    logic        SLVRESP;

    modport master (
        output SLVADDR, SLVWDATA, SLVTRANS, SLVWRITE, SLVSIZE,
        input  SLVRDATA, SLVREADY, SLVRESP
    );
    modport slave (
        input  SLVADDR, SLVWDATA, SLVTRANS, SLVWRITE, SLVSIZE,
        output SLVRDATA, SLVREADY, SLVRESP
    );
endinterface

interface cm0_dap_ahb_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );
    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/cm0_dap_slv_ahb_bridge.sv
// Single-transfer bridge from the DAP access port SLV* master to one AHB-Lite transfer.
// Optional data-phase timeout with DRAIN state: define CM0_DAP_BRIDGE_TIMEOUT_EN.
module cm0_dap_slv_ahb_bridge #(
    parameter int TIMEOUT_W = 8
) (
    input  logic          DCLK,
    input  logic          APRESET,
    cm0_dap_slv_if.slave  slv,
    cm0_dap_ahb_if.master ahb
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
`ifdef CM0_DAP_BRIDGE_TIMEOUT_EN
        ST_DRAIN = 3'd4,
`endif
        ST_DONE  = 3'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_slvrdata, w_slvrdata_nxt;
    logic        r_slvready, w_slvready_nxt;
    logic        r_slvresp,  w_slvresp_nxt;
    logic [31:0] r_haddr,    w_haddr_nxt;
    logic [1:0]  r_htrans,   w_htrans_nxt;
    logic        r_hwrite,   w_hwrite_nxt;
    logic [1:0]  r_hsize,    w_hsize_nxt;
    logic [31:0] r_hwdata,   w_hwdata_nxt;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_timeout;

    assign w_accept     = (r_state == ST_IDLE) && slv.SLVTRANS[1];
    assign w_misaligned = (slv.SLVSIZE == 2'd3)
                       || ((slv.SLVSIZE == 2'd1) && slv.SLVADDR[0])
                       || ((slv.SLVSIZE == 2'd2) && (slv.SLVADDR[1:0] != 2'b00));

`ifdef CM0_DAP_BRIDGE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_tmo_cnt;
    logic                 w_in_flight;

    assign w_in_flight = (r_state == ST_ADDR) || (r_state == ST_DATA);
    // Only a genuinely stalled bus times out; a completing HREADY wins.
    assign w_timeout   = w_in_flight && (&r_tmo_cnt) && !ahb.HREADY;

    always_ff @(posedge DCLK) begin
        if (APRESET) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (w_in_flight && !(&r_tmo_cnt)) begin
            r_tmo_cnt <= r_tmo_cnt + TIMEOUT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge DCLK) begin
        if (APRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (slv.SLVTRANS[1]) begin
                    w_state_nxt = w_misaligned ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
`ifdef CM0_DAP_BRIDGE_TIMEOUT_EN
                if (w_timeout) w_state_nxt = ST_DRAIN;
                else
`endif
                if (ahb.HREADY) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
`ifdef CM0_DAP_BRIDGE_TIMEOUT_EN
                if (w_timeout) w_state_nxt = ST_DRAIN;
                else
`endif
                if (ahb.HREADY) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
`ifdef CM0_DAP_BRIDGE_TIMEOUT_EN
            ST_DRAIN: begin
                if (ahb.HREADY) w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_slvrdata_nxt = r_slvrdata;
        w_slvready_nxt = 1'b0;
        w_slvresp_nxt  = 1'b0;
        w_haddr_nxt    = r_haddr;
        w_hwrite_nxt   = r_hwrite;
        w_hsize_nxt    = r_hsize;
        w_hwdata_nxt   = r_hwdata;
        w_htrans_nxt   = (w_state_nxt == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;

        if (w_accept && !w_misaligned) begin
            w_haddr_nxt  = slv.SLVADDR;
            w_hwrite_nxt = slv.SLVWRITE;
            w_hsize_nxt  = slv.SLVSIZE;
            w_hwdata_nxt = slv.SLVWDATA;
        end

        // Misaligned requests are answered locally without touching the bus.
        if (w_accept && w_misaligned) begin
            w_slvready_nxt = 1'b1;
            w_slvresp_nxt  = 1'b1;
        end

        if ((r_state == ST_DATA) && ahb.HREADY) begin
            w_slvready_nxt = 1'b1;
            w_slvresp_nxt  = ahb.HRESP;
            if (!r_hwrite) begin
                w_slvrdata_nxt = ahb.HRDATA;
            end
        end

        if (w_timeout) begin
            w_slvready_nxt = 1'b1;
            w_slvresp_nxt  = 1'b1;
        end
    end

    always_ff @(posedge DCLK) begin
        if (APRESET) begin
            r_slvrdata <= '0;
            r_slvready <= 1'b0;
            r_slvresp  <= 1'b0;
            r_haddr    <= '0;
            r_htrans   <= HTRANS_IDLE;
            r_hwrite   <= 1'b0;
            r_hsize    <= '0;
            r_hwdata   <= '0;
        end else begin
            r_slvrdata <= w_slvrdata_nxt;
            r_slvready <= w_slvready_nxt;
            r_slvresp  <= w_slvresp_nxt;
            r_haddr    <= w_haddr_nxt;
            r_htrans   <= w_htrans_nxt;
            r_hwrite   <= w_hwrite_nxt;
            r_hsize    <= w_hsize_nxt;
            r_hwdata   <= w_hwdata_nxt;
        end
    end

    assign slv.SLVRDATA  = r_slvrdata;
    assign slv.SLVREADY  = r_slvready;
    assign slv.SLVRESP   = r_slvresp;

    assign ahb.HADDR     = r_haddr;
    assign ahb.HTRANS    = r_htrans;
    assign ahb.HWRITE    = r_hwrite;
    assign ahb.HSIZE     = {1'b0, r_hsize};
    assign ahb.HWDATA    = r_hwdata;
    assign ahb.HBURST    = 3'b000;
    assign ahb.HPROT     = 4'b0011;
    assign ahb.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_cm0_dap_slv_ahb_bridge.sv
// Self-checking bench for cm0_dap_slv_ahb_bridge: directed table, corner sequences, random requests.
// Define CM0_DAP_BRIDGE_TIMEOUT_EN to also exercise the timeout/DRAIN path (TIMEOUT_W = 4).
`timescale 1ns/1ps
module tb_cm0_dap_slv_ahb_bridge;

`ifdef CM0_DAP_BRIDGE_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 8;
`endif

    logic DCLK = 1'b0;
    logic APRESET;

    cm0_dap_slv_if slv ();
    cm0_dap_ahb_if ahb ();

    cm0_dap_slv_ahb_bridge #(.TIMEOUT_W(TW)) dut (
        .DCLK    (DCLK),
        .APRESET (APRESET),
        .slv     (slv),
        .ahb     (ahb)
    );

    always #5 DCLK = ~DCLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] hrdata;
        logic        write;
        logic [1:0]  size;
        logic [1:0]  trans;
        int          aw;
        int          dw;
        logic        err;
        int          exp_lat;
        logic        exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_rdata = '0;
    vec_t        tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge DCLK);
        #1;
    endtask

    function automatic bit is_mis(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || ((size == 2'd1) && addr[0]) ||
               ((size == 2'd2) && (addr[1:0] != 2'b00));
    endfunction

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] hrdata, input logic write,
                                input logic [1:0] size, input logic [1:0] trans,
                                input int aw, input int dw, input logic err,
                                input int lat, input logic resp, input logic [31:0] rdata);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.hrdata = hrdata; v.write = write;
        v.size = size; v.trans = trans; v.aw = aw; v.dw = dw; v.err = err;
        v.exp_lat = lat; v.exp_resp = resp; v.exp_rdata = rdata;
        return v;
    endfunction

    // Reference: latency is 3 plus every wait cycle, misaligned answers in 1; reads update SLVRDATA.
    function automatic vec_t rand_vec();
        vec_t v;
        v.size = 2'($urandom_range(0, 3));
        v.addr = $urandom();
        if ($urandom_range(0, 3) != 0) begin
            if (v.size == 2'd1) v.addr[0] = 1'b0;
            else if (v.size == 2'd2) v.addr[1:0] = 2'b00;
        end
        v.wdata  = $urandom();
        v.hrdata = $urandom();
        v.write  = 1'($urandom_range(0, 1));
        v.trans  = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
        v.aw     = int'($urandom_range(0, 3));
        v.dw     = int'($urandom_range(0, 3));
        v.err    = (v.dw > 0) && ($urandom_range(0, 3) == 0);
        if (is_mis(v.size, v.addr)) begin
            v.exp_lat = 1; v.exp_resp = 1'b1; v.exp_rdata = model_rdata;
        end else begin
            v.exp_lat   = 3 + v.aw + v.dw;
            v.exp_resp  = v.err;
            v.exp_rdata = v.write ? model_rdata : v.hrdata;
        end
        return v;
    endfunction

    // Issues one request from IDLE and plays an AHB slave with v.aw/v.dw wait cycles.
    task automatic run_req(input string tag, input vec_t v);
        int          lat;
        int          nonseq;
        int          done_c;
        bit          mis;
        bit          ctrl_ok;
        bit          wdata_ok;
        bit          pulse_ok;
        logic        rdy_resp;
        logic [31:0] rdy_rdata;
        lat = 0; nonseq = 0; ctrl_ok = 1'b1; wdata_ok = 1'b1;
        rdy_resp = 1'b0; rdy_rdata = '0;
        mis    = is_mis(v.size, v.addr);
        done_c = v.aw + v.dw + 2;
        slv.SLVADDR = v.addr; slv.SLVWDATA = v.wdata; slv.SLVWRITE = v.write;
        slv.SLVSIZE = v.size; slv.SLVTRANS = v.trans;
        ahb.HREADY = 1'b1; ahb.HRESP = 1'b0; ahb.HRDATA = $urandom();
        for (int c = 1; c <= 64 && lat == 0; c++) begin
            step();
            if (mis || c > done_c) ahb.HREADY = 1'b1;
            else ahb.HREADY = (c == v.aw + 1) || (c == done_c);
            ahb.HRESP  = !mis && v.err && ((c == done_c - 1) || (c == done_c));
            ahb.HRDATA = (c == done_c) ? v.hrdata : $urandom();
            @(negedge DCLK);
            if (ahb.HTRANS == 2'b10) begin
                nonseq++;
                if (ahb.HADDR !== v.addr || ahb.HWRITE !== v.write || ahb.HSIZE !== {1'b0, v.size})
                    ctrl_ok = 1'b0;
            end
            if (!mis && v.write && c >= v.aw + 2 && c <= done_c && ahb.HWDATA !== v.wdata)
                wdata_ok = 1'b0;
            if (slv.SLVREADY) begin
                lat = c; rdy_resp = slv.SLVRESP; rdy_rdata = slv.SLVRDATA;
                slv.SLVTRANS = 2'b00;
            end
        end
        slv.SLVTRANS = 2'b00;
        step();
        ahb.HREADY = 1'b1; ahb.HRESP = 1'b0;
        @(negedge DCLK);
        pulse_ok = !slv.SLVREADY && !slv.SLVRESP;
        step();
        check({tag, ".lat"},    lat,       v.exp_lat);
        check({tag, ".resp"},   rdy_resp,  v.exp_resp);
        check({tag, ".rdata"},  rdy_rdata, v.exp_rdata);
        check({tag, ".nonseq"}, nonseq,    mis ? 0 : v.aw + 1);
        check({tag, ".ctrl"},   ctrl_ok,   1'b1);
        check({tag, ".hwdata"}, wdata_ok,  1'b1);
        check({tag, ".pulse"},  pulse_ok,  1'b1);
        model_rdata = v.exp_rdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [11:0] nonseq_mask;
        logic [11:0] ready_mask;

        slv.SLVADDR = '0; slv.SLVWDATA = '0; slv.SLVTRANS = 2'b00;
        slv.SLVWRITE = 1'b0; slv.SLVSIZE = 2'd0;
        ahb.HRDATA = '0; ahb.HREADY = 1'b1; ahb.HRESP = 1'b0;

        // Reset state
        APRESET = 1'b1;
        repeat (3) @(posedge DCLK);
        #1;
        APRESET = 1'b0;
        @(negedge DCLK);
        check("rst.slvrdata",  slv.SLVRDATA,  32'h0);
        check("rst.slvready",  slv.SLVREADY,  1'b0);
        check("rst.slvresp",   slv.SLVRESP,   1'b0);
        check("rst.haddr",     ahb.HADDR,     32'h0);
        check("rst.htrans",    ahb.HTRANS,    2'b00);
        check("rst.hwrite",    ahb.HWRITE,    1'b0);
        check("rst.hsize",     ahb.HSIZE,     3'd0);
        check("rst.hwdata",    ahb.HWDATA,    32'h0);
        check("const.hburst",  ahb.HBURST,    3'b000);
        check("const.hprot",   ahb.HPROT,     4'b0011);
        check("const.hlock",   ahb.HMASTLOCK, 1'b0);
        step();
        model_rdata = '0;

        // Directed table: addr, wdata, hrdata, write, size, trans, aw, dw, err, lat, resp, rdata
        tbl[0] = mk(32'h2000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2'd2, 2'b10, 0, 0, 1'b0, 3, 1'b0, 32'hDEAD_BEEF);
        tbl[1] = mk(32'h2000_0020, 32'h1234_5678, 32'h5555_AAAA, 1'b1, 2'd2, 2'b10, 0, 2, 1'b0, 5, 1'b0, 32'hDEAD_BEEF);
        tbl[2] = mk(32'h2000_0001, 32'h0,         32'h1111_1111, 1'b0, 2'd1, 2'b10, 0, 0, 1'b0, 1, 1'b1, 32'hDEAD_BEEF);
        tbl[3] = mk(32'h2000_0000, 32'h0,         32'h2222_2222, 1'b0, 2'd3, 2'b11, 0, 0, 1'b0, 1, 1'b1, 32'hDEAD_BEEF);
        tbl[4] = mk(32'h2000_0002, 32'hFFFF_0000, 32'h3333_3333, 1'b1, 2'd2, 2'b10, 1, 1, 1'b0, 1, 1'b1, 32'hDEAD_BEEF);
        tbl[5] = mk(32'h4000_0000, 32'hA5A5_5A5A, 32'h4444_4444, 1'b1, 2'd2, 2'b10, 0, 1, 1'b1, 4, 1'b1, 32'hDEAD_BEEF);
        tbl[6] = mk(32'h1000_0003, 32'h0,         32'hA5A5_0001, 1'b0, 2'd0, 2'b11, 2, 1, 1'b0, 6, 1'b0, 32'hA5A5_0001);
        tbl[7] = mk(32'h1000_0002, 32'h0,         32'h0000_BEEF, 1'b0, 2'd1, 2'b10, 1, 0, 1'b0, 4, 1'b0, 32'h0000_BEEF);
        tbl[8] = mk(32'h0000_0000, 32'h0,         32'hBAD0_0BAD, 1'b0, 2'd2, 2'b10, 0, 1, 1'b1, 4, 1'b1, 32'hBAD0_0BAD);
        for (int i = 0; i < 9; i++) run_req($sformatf("tbl%0d", i), tbl[i]);

        // Back-to-back with SLVTRANS held high: one transfer every 4 cycles
        nonseq_mask = '0; ready_mask = '0;
        slv.SLVADDR = 32'h0000_0050; slv.SLVWRITE = 1'b0; slv.SLVSIZE = 2'd2;
        slv.SLVTRANS = 2'b10; ahb.HREADY = 1'b1; ahb.HRDATA = 32'h0BAD_CAFE;
        for (int c = 1; c <= 11; c++) begin
            step();
            @(negedge DCLK);
            nonseq_mask[c] = (ahb.HTRANS == 2'b10);
            ready_mask[c]  = slv.SLVREADY;
            if (c == 11) slv.SLVTRANS = 2'b00;
        end
        step();
        step();
        check("b2b.nonseq", nonseq_mask, 12'h222);
        check("b2b.ready",  ready_mask,  12'h888);
        model_rdata = 32'h0BAD_CAFE;

        // APRESET during a stalled data phase
        slv.SLVADDR = 32'h3000_0004; slv.SLVWDATA = 32'hCAFE_F00D; slv.SLVWRITE = 1'b1;
        slv.SLVSIZE = 2'd2; slv.SLVTRANS = 2'b10; ahb.HREADY = 1'b1;
        step();
        ahb.HREADY = 1'b1;
        step();
        ahb.HREADY = 1'b0;
        APRESET = 1'b1;
        @(negedge DCLK);
        check("mrst.pre_hwdata", ahb.HWDATA, 32'hCAFE_F00D);
        step();
        APRESET = 1'b0;
        slv.SLVTRANS = 2'b00;
        @(negedge DCLK);
        check("mrst.htrans",   ahb.HTRANS,   2'b00);
        check("mrst.slvready", slv.SLVREADY, 1'b0);
        check("mrst.slvrdata", slv.SLVRDATA, 32'h0);
        check("mrst.haddr",    ahb.HADDR,    32'h0);
        check("mrst.hwdata",   ahb.HWDATA,   32'h0);
        step();
        model_rdata = '0;
        run_req("mrst.next", mk(32'h3000_0008, 32'h0, 32'h7777_0001, 1'b0, 2'd2, 2'b10,
                                0, 0, 1'b0, 3, 1'b0, 32'h7777_0001));

`ifdef CM0_DAP_BRIDGE_TIMEOUT_EN
        begin : tmo_seq
            int          lat;
            bit          quiet;
            logic        resp;
            logic [31:0] rdata;
            lat = 0; quiet = 1'b1; resp = 1'b0; rdata = '0;
            slv.SLVADDR = 32'h6000_0000; slv.SLVWDATA = 32'h1357_9BDF; slv.SLVWRITE = 1'b1;
            slv.SLVSIZE = 2'd2; slv.SLVTRANS = 2'b10; ahb.HREADY = 1'b0;
            for (int c = 1; c <= 40 && lat == 0; c++) begin
                step();
                ahb.HREADY = 1'b0;
                @(negedge DCLK);
                if (slv.SLVREADY) begin
                    lat = c; resp = slv.SLVRESP; rdata = slv.SLVRDATA;
                end
            end
            check("tmo.lat",   lat,   (1 << TW) + 1);
            check("tmo.resp",  resp,  1'b1);
            check("tmo.rdata", rdata, model_rdata);
            slv.SLVADDR = 32'h6000_0010; slv.SLVWRITE = 1'b0;
            for (int k = 0; k < 4; k++) begin
                step();
                ahb.HREADY = 1'b0;
                @(negedge DCLK);
                if (ahb.HTRANS != 2'b00 || slv.SLVREADY) quiet = 1'b0;
            end
            check("tmo.drain_quiet", quiet, 1'b1);
            step();
            ahb.HREADY = 1'b1; ahb.HRDATA = 32'h0D0D_0D0D;
            step();
            @(negedge DCLK);
            check("tmo.idle", ahb.HTRANS, 2'b00);
            step();
            @(negedge DCLK);
            check("tmo.nonseq", ahb.HTRANS, 2'b10);
            step();
            step();
            @(negedge DCLK);
            check("tmo.next_ready", slv.SLVREADY, 1'b1);
            check("tmo.next_rdata", slv.SLVRDATA, 32'h0D0D_0D0D);
            slv.SLVTRANS = 2'b00;
            step();
            step();
            model_rdata = 32'h0D0D_0D0D;
        end
`endif

        // Randomized requests against the reference
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v = rand_vec();
            run_req($sformatf("rnd%0d", i), v);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
